// File: rtl/cpu_trace_buffer_pkg.sv
// Shared types for the CPU trace capture block.
// States, trigger modes and the trigger compare helper.
package trace_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    POST = 3'd2,
    DONE = 3'd3,
    READ = 3'd4
  } trace_state_t;

  typedef enum logic [1:0] {
    TRIG_IMM   = 2'd0,
    TRIG_PC    = 2'd1,
    TRIG_IR    = 2'd2,
    TRIG_PC_IR = 2'd3
  } trace_mode_t;

  function automatic logic trig_match(
    input trace_mode_t mode,
    input logic [15:0] pc,
    input logic [7:0]  ir,
    input logic [15:0] trig_pc,
    input logic [7:0]  trig_ir
  );
    logic pc_hit;
    logic ir_hit;
    logic hit;
    pc_hit = (pc == trig_pc);
    ir_hit = (ir == trig_ir);
    case (mode)
      TRIG_IMM:   hit = 1'b1;
      TRIG_PC:    hit = pc_hit;
      TRIG_IR:    hit = ir_hit;
      TRIG_PC_IR: hit = pc_hit & ir_hit;
      default:    hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/cpu_trace_buffer_if.sv
// Trace readout port: valid/ready stream of {timestamp, snapshot}.
// Master drives entries, slave accepts them.
interface cpu_trace_buffer_if #(
  parameter int CNT_W  = 32,
  parameter int DATA_W = 64
);

  logic                    rd_valid;
  logic                    rd_ready;
  logic [CNT_W+DATA_W-1:0] rd_data;
  logic                    rd_last;

  modport master (
    output rd_valid,
    output rd_data,
    output rd_last,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_data,
    input  rd_last,
    output rd_ready
  );

endinterface

// File: rtl/cpu_trace_buffer_ram.sv
// Trace storage: one write port, one registered read port.
// Read data holds when no read is issued.
module trace_ram #(
  parameter int DEPTH = 64,
  parameter int W     = 96,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Instruction-boundary trace capture with pre/post trigger window.
// Entries are drained oldest-first over a valid/ready port.
module cpu_trace_buffer
  import trace_pkg::*;
#(
  parameter int  DEPTH  = 64,
  parameter int  DATA_W = 64,
  parameter int  CNT_W  = 32,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [15:0]       pc,
  input  logic [7:0]        ir,
  input  logic              arm,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [15:0]       trig_pc,
  input  logic [7:0]        trig_ir,
  input  logic [PTR_W:0]    post_count,
  cpu_trace_buffer_if.master rd,
  output logic              busy,
  output logic [2:0]        state_o
);

  localparam logic [PTR_W:0]   FULL    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PMAX    = PTR_W'(DEPTH-1);
  localparam logic [PTR_W-1:0] P_ONE   = PTR_W'(1);

  trace_state_t     state;
  trace_state_t     state_d;
  trace_mode_t      mode_q;
  logic [15:0]      tpc_q;
  logic [7:0]       tir_q;
  logic [PTR_W-1:0] post_q;
  logic [PTR_W-1:0] post_rem;
  logic             trig_seen;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   remaining;
  logic [CNT_W-1:0] ts;

  logic             wr_en;
  logic             arm_go;
  logic             hit;
  logic             post_dec;
  logic             last_post;
  logic             accept;
  logic             fetch_next;
  logic             rd_en;
  logic [PTR_W-1:0] rd_addr;
  logic [PTR_W-1:0] post_clamp;

  assign post_clamp = (post_count >= FULL) ? PMAX
                                           : post_count[PTR_W-1:0];

  always_comb begin
    wr_en      = 1'b0;
    arm_go     = 1'b0;
    hit        = 1'b0;
    post_dec   = 1'b0;
    last_post  = 1'b0;
    accept     = 1'b0;
    fetch_next = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = rd_ptr;
    if (!abort) begin
      arm_go = (state == IDLE) && arm;
      wr_en  = sample_en && ((state == PRE) || (state == POST));
      if (wr_en && state == PRE) begin
        hit = trig_match(mode_q, pc, ir, tpc_q, tir_q);
      end
      if (wr_en && state == POST) begin
        hit      = !trig_seen;
        post_dec = trig_seen;
      end
      last_post  = post_dec && (post_rem == P_ONE);
      accept     = (state == READ) && rd.rd_ready;
      fetch_next = accept && (remaining > CNT_ONE);
      if (state == DONE) begin
        rd_en   = 1'b1;
        rd_addr = wr_ptr - count[PTR_W-1:0];
      end else if (fetch_next) begin
        rd_en = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            state_d = (trace_mode_t'(mode) == TRIG_IMM) ? POST : PRE;
          end
        end
        PRE: begin
          if (hit) begin
            state_d = (post_q == '0) ? DONE : POST;
          end
        end
        POST: begin
          if ((hit && post_q == '0) || last_post) begin
            state_d = DONE;
          end
        end
        DONE:    state_d = READ;
        READ: begin
          if (accept && remaining == CNT_ONE) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts        <= '0;
      mode_q    <= TRIG_IMM;
      tpc_q     <= '0;
      tir_q     <= '0;
      post_q    <= '0;
      post_rem  <= '0;
      trig_seen <= 1'b0;
      wr_ptr    <= '0;
      count     <= '0;
      rd_ptr    <= '0;
      remaining <= '0;
    end else begin
      ts <= ts + 1'b1;
      if (abort) begin
        count     <= '0;
        remaining <= '0;
      end else begin
        if (arm_go) begin
          mode_q    <= trace_mode_t'(mode);
          tpc_q     <= trig_pc;
          tir_q     <= trig_ir;
          post_q    <= post_clamp;
          trig_seen <= 1'b0;
          wr_ptr    <= '0;
          count     <= '0;
        end
        if (wr_en) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (count != FULL) begin
            count <= count + 1'b1;
          end
        end
        if (hit) begin
          trig_seen <= 1'b1;
          post_rem  <= post_q;
        end else if (post_dec) begin
          post_rem <= post_rem - 1'b1;
        end
        // DONE fetches the oldest entry; rd_ptr then tracks the next fetch
        if (state == DONE) begin
          rd_ptr    <= rd_addr + 1'b1;
          remaining <= count;
        end
        if (accept) begin
          remaining <= remaining - 1'b1;
          if (fetch_next) begin
            rd_ptr <= rd_ptr + 1'b1;
          end
        end
      end
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .W     (CNT_W + DATA_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata ({ts, sample_data}),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd.rd_data)
  );

  assign rd.rd_valid = (state == READ);
  assign rd.rd_last  = (state == READ) && (remaining == CNT_ONE);
  assign busy        = (state != IDLE);
  assign state_o     = state;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Bench for cpu_trace_buffer: queue-level reference model,
// directed scenarios with literal expectations, then random traffic.
module tb_cpu_trace_buffer;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 32;
  localparam int W      = CNT_W + DATA_W;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_en;
  logic [63:0] sample_data;
  logic [15:0] pc;
  logic [7:0]  ir;
  logic        arm;
  logic        abort;
  logic [1:0]  mode;
  logic [15:0] trig_pc;
  logic [7:0]  trig_ir;
  logic [3:0]  post_count;
  logic        busy;
  logic [2:0]  state_o;

  always #5 clk = ~clk;

  cpu_trace_buffer_if #(.CNT_W(CNT_W), .DATA_W(DATA_W)) rd();

  cpu_trace_buffer #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_en   (sample_en),
    .sample_data (sample_data),
    .pc          (pc),
    .ir          (ir),
    .arm         (arm),
    .abort       (abort),
    .mode        (mode),
    .trig_pc     (trig_pc),
    .trig_ir     (trig_ir),
    .post_count  (post_count),
    .rd          (rd.master),
    .busy        (busy),
    .state_o     (state_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference model: plain queues of {ts, data}
  logic [W-1:0] mq[$];
  logic [W-1:0] rq[$];
  logic [W-1:0] got[$];
  bit           got_last[$];
  bit           live = 0;
  int           m_state = 0;
  bit [31:0]    m_ts = 0;
  bit [31:0]    ts_now;
  int           m_mode, m_post, m_rem;
  bit [15:0]    m_tpc;
  bit [7:0]     m_tir;
  bit           m_seen;
  bit           m_match;
  logic [W-1:0] e_data;

  task automatic m_push(input bit [31:0] t);
    mq.push_back({t, sample_data});
    if (mq.size() > DEPTH) void'(mq.pop_front());
  endtask

  task automatic m_trig();
    m_seen = 1;
    if (m_post == 0) m_state = 3;
    else begin
      m_rem   = m_post;
      m_state = 2;
    end
  endtask

  always @(posedge clk) begin
    if (live && rd.rd_valid === 1'b1 && rd.rd_ready === 1'b1) begin
      got.push_back(rd.rd_data);
      got_last.push_back(rd.rd_last);
    end
    if (rst) begin
      live    = 1;
      m_state = 0;
      m_ts    = 0;
      mq.delete();
      rq.delete();
    end else if (live) begin
      ts_now = m_ts;
      m_ts   = m_ts + 1;
      if (abort) begin
        m_state = 0;
        mq.delete();
        rq.delete();
      end else begin
        case (m_state)
          0: if (arm) begin
            m_mode = mode;
            m_tpc  = trig_pc;
            m_tir  = trig_ir;
            m_post = (post_count > DEPTH - 1) ? DEPTH - 1 : post_count;
            m_seen = 0;
            mq.delete();
            m_state = (mode == 0) ? 2 : 1;
          end
          1: if (sample_en) begin
            m_push(ts_now);
            m_match = (m_mode == 1) ? (pc == m_tpc) :
                      (m_mode == 2) ? (ir == m_tir) :
                      ((pc == m_tpc) && (ir == m_tir));
            if (m_match) m_trig();
          end
          2: if (sample_en) begin
            m_push(ts_now);
            if (!m_seen) m_trig();
            else begin
              m_rem--;
              if (m_rem == 0) m_state = 3;
            end
          end
          3: begin
            rq = mq;
            m_state = 4;
          end
          default: if (rd.rd_ready) begin
            void'(rq.pop_front());
            if (rq.size() == 0) m_state = 0;
          end
        endcase
      end
    end
    #1;
    if (live) begin
      chk("state", state_o, m_state);
      chk("busy", busy, m_state != 0);
      chk("rd_valid", rd.rd_valid, m_state == 4);
      chk("rd_last", rd.rd_last, (m_state == 4) && (rq.size() == 1));
      if (m_state == 4 && rq.size() > 0) begin
        e_data = rq[0];
        chk("rd_data", rd.rd_data, e_data);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy === 1'b1 && n < bound) begin
      tick();
      n++;
    end
    chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic check_beats(input string nm, input int n,
                             input logic [63:0] first);
    chk({nm, "_count"}, got.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < got.size()) begin
        chk({nm, "_data"}, got[i][63:0], first + 64'(i));
        chk({nm, "_last"}, got_last[i], i == n - 1);
      end
    end
  endtask

  task automatic do_arm(input logic [1:0] md, input logic [15:0] tp,
                        input logic [7:0] ti, input logic [3:0] pcnt);
    arm = 1; mode = md; trig_pc = tp; trig_ir = ti; post_count = pcnt;
    tick();
    arm = 0;
  endtask

  task automatic sample(input logic [63:0] d, input logic [15:0] p,
                        input logic [7:0] i);
    sample_en = 1; sample_data = d; pc = p; ir = i;
    tick();
    sample_en = 0;
  endtask

  initial begin
    rst = 1; sample_en = 0; sample_data = '0; pc = '0; ir = '0;
    arm = 0; abort = 0; mode = '0; trig_pc = '0; trig_ir = '0;
    post_count = '0; rd.rd_ready = 0;
    repeat (2) tick();
    chk("rst_valid", rd.rd_valid, 1'b0);
    chk("rst_last", rd.rd_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_state", state_o, 3'd0);
    chk("rst_data", rd.rd_data, '0);
    rst = 0;

    // IMM capture, arm in the first post-reset cycle (ts=0)
    got.delete(); got_last.delete();
    do_arm(2'd0, 16'h0, 8'h0, 4'd3);
    for (int i = 0; i < 4; i++) sample(64'hA0 + 64'(i), 16'h0, 8'h0);
    rd.rd_ready = 1;
    wait_idle(40);
    check_beats("imm", 4, 64'hA0);
    for (int i = 0; i < 4; i++)
      if (i < got.size()) chk("imm_ts", got[i][95:64], i + 1);

    // PC trigger after wrap, with backpressure
    got.delete(); got_last.delete();
    rd.rd_ready = 0;
    do_arm(2'd1, 16'h0150, 8'h0, 4'd2);
    for (int i = 0; i < 20; i++) sample(64'(i), 16'h0100 + 16'(i), 8'h0);
    sample(64'd20, 16'h0150, 8'h0);
    sample(64'd21, 16'h0200, 8'h0);
    sample(64'd22, 16'h0201, 8'h0);
    for (int n = 0; n < 10 && rd.rd_valid !== 1'b1; n++) tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rd.rd_valid, 1'b1);
      chk("bp_data", rd.rd_data[63:0], 64'd15);
      tick();
    end
    rd.rd_ready = 1;
    repeat (8) tick();
    chk("bp_nogap_busy", busy, 1'b0);
    check_beats("pc", 8, 64'd15);

    // abort mid-POST with a simultaneous arm
    got.delete(); got_last.delete();
    do_arm(2'd0, 16'h0, 8'h0, 4'd5);
    sample(64'h1, 16'h0, 8'h0);
    sample(64'h2, 16'h0, 8'h0);
    abort = 1; arm = 1; sample_en = 1;
    tick();
    abort = 0; arm = 0; sample_en = 0;
    chk("abort_state", state_o, 3'd0);
    tick();
    chk("abort_arm_ign", busy, 1'b0);
    chk("abort_nobeat", got.size(), 0);
    do_arm(2'd0, 16'h0, 8'h0, 4'd0);
    sample(64'h55, 16'h0, 8'h0);
    wait_idle(20);
    check_beats("rearm", 1, 64'h55);

    // IR trigger on the first sample, no post samples
    got.delete(); got_last.delete();
    do_arm(2'd2, 16'h0, 8'h76, 4'd0);
    sample(64'h99, 16'h1234, 8'h76);
    wait_idle(20);
    check_beats("ir", 1, 64'h99);

    // post_count 9 clamps to 7: trigger + 7 samples
    got.delete(); got_last.delete();
    do_arm(2'd0, 16'h0, 8'h0, 4'd9);
    for (int i = 0; i < 10; i++) sample(64'(i), 16'h0, 8'h0);
    wait_idle(40);
    check_beats("clamp", 8, 64'd0);

    // randomized traffic checked by the model every cycle
    for (int c = 0; c < 4000; c++) begin
      rst         = ($urandom_range(0, 999) == 0);
      abort       = ($urandom_range(0, 79) == 0);
      arm         = ($urandom_range(0, 7) == 0);
      mode        = 2'($urandom_range(0, 3));
      trig_pc     = 16'h0010 + 16'($urandom_range(0, 3));
      trig_ir     = 8'h70 + 8'($urandom_range(0, 3));
      post_count  = 4'($urandom_range(0, 10));
      sample_en   = ($urandom_range(0, 1) == 1);
      sample_data = {32'($urandom), 32'($urandom)};
      pc          = 16'h0010 + 16'($urandom_range(0, 3));
      ir          = 8'h70 + 8'($urandom_range(0, 3));
      rd.rd_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    rst = 0; arm = 0; sample_en = 0; abort = 1;
    tick();
    abort = 0;
    tick();
    chk("final_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
- Synthesizable trace capture block that replaces simulation-only `$monitor` tracing of the CPU datapath.
- On each instruction-boundary strobe it records a caller-packed snapshot (PC, IR, SP, registers, flags) plus a cycle timestamp into a circular buffer.
- Supports pre/post-trigger capture with selectable trigger modes.
- Captured entries are drained oldest-first over a valid/ready read port, for use by the debug UART or a bench.

Parameters:
- DEPTH, 64, number of entries; must be a power of two, >= 4.
- DATA_W, 64, width of the snapshot word supplied by the caller.
- CNT_W, 32, width of the free-running cycle timestamp.
- PTR_W, $clog2(DEPTH), derived; not overridden.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- sample_en  in  1  one-cycle strobe at an instruction boundary.
- sample_data  in  DATA_W  snapshot to record when sample_en=1.
- pc  in  16  PC of the current sample, used for trigger compare.
- ir  in  8  opcode of the current sample, used for trigger compare.
- arm  in  1  start a capture; honoured only in IDLE.
- abort  in  1  cancel capture or readout; return to IDLE.
- mode  in  2  0=IMM, 1=PC match, 2=IR match, 3=PC and IR match; latched at arm.
- trig_pc  in  16  PC compare value; latched at arm.
- trig_ir  in  8  IR compare value; latched at arm.
- post_count  in  PTR_W+1  samples kept after the trigger sample; latched at arm, clamped to DEPTH-1.
- rd_valid  out  1  rd_data holds a valid entry.
- rd_ready  in  1  consumer accepts the entry.
- rd_data  out  CNT_W+DATA_W  {timestamp, snapshot}.
- rd_last  out  1  qualifies the final entry of the capture.
- busy  out  1  state != IDLE.
- state_o  out  3  current FSM state, for debug.

Behaviour:
- Reset: all outputs are 0; state=IDLE; wr_ptr, count and timestamp are 0. Buffer RAM contents are not reset.
- Timestamp counter increments every cycle from reset and wraps modulo 2^CNT_W. The value stored is the counter value in the sample_en cycle.
- States: IDLE, PRE, POST, DONE, READ.
- IDLE, on arm=1: latch mode, trig_pc, trig_ir and min(post_count, DEPTH-1); clear count and wr_ptr. Go to POST if mode=IMM, else PRE.
- Write rule: in PRE/POST, a sample_en cycle writes sample_data at wr_ptr, then wr_ptr++ (wraps) and count = min(count+1, DEPTH).
- Samples arriving in IDLE/DONE/READ are ignored.
- PRE: each written sample is compared against the trigger using that same cycle's pc/ir.
  - On a match, that sample is the trigger sample.
  - If latched post_count=0, go to DONE; else load post_rem=post_count and go to POST.
  - With no match, the buffer overwrites the oldest entry indefinitely.
- POST:
  - In IMM mode, the first sample is the trigger sample and is handled like the PRE match case.
  - Each further written sample decrements post_rem; when post_rem reaches 0 after that write, go to DONE.
- DONE (exactly 1 cycle):
  - rd_ptr = wr_ptr - count (mod DEPTH).
  - Issue the RAM read; remaining = count.
  - Go to READ.
- READ:
  - rd_valid=1 from the first READ cycle. rd_data is registered and held stable while rd_valid=1 and rd_ready=0.
  - rd_last=1 when remaining=1.
  - On rd_valid and rd_ready: remaining--, rd_ptr++, and the next entry is presented on the following cycle with no bubble; the RAM read is prefetched.
  - On acceptance with rd_last=1: go to IDLE, rd_valid=0.
- abort has priority over all other inputs in any state: next cycle state=IDLE, rd_valid=0, rd_last=0, count=0.
- arm and abort in the same IDLE cycle: abort wins, so the block stays IDLE.
- arm outside IDLE: ignored.
- rst mid-operation: identical to abort, and additionally clears the timestamp.
- Captured entry count is min(total samples written, DEPTH); the capture always ends with the post-trigger samples.

Decomposition:
- Package trace_pkg holds:
  - trace_state_t enum (IDLE=0, PRE, POST, DONE, READ);
  - trace_mode_t enum (TRIG_IMM, TRIG_PC, TRIG_IR, TRIG_PC_IR);
  - helper function trig_match(mode, pc, ir, trig_pc, trig_ir).
- Sub-module trace_ram: simple dual-port, 1 write and 1 registered read, DEPTH x (CNT_W+DATA_W).

Test Plan:
- Reset: assert rst 2 cycles -> rd_valid=0, rd_last=0, busy=0, state_o=0; timestamp 0 on the first post-reset cycle.
- IMM mode, DEPTH=8, post_count=3, four samples with data 0xA0..0xA3 -> 4 beats A0..A3; rd_last on A3; timestamps strictly increasing; busy=0 after the final accept.
- PC trigger with wrap, DEPTH=8:
  - 20 samples with pc=0x0100+i and data=i, trig_pc=0x0150;
  - then a sample with pc=0x0150, data=20, post_count=2, then data 21 and 22;
  - -> 8 beats with data 15..22; rd_last on 22.
- Backpressure: during READ, hold rd_ready=0 for 5 cycles -> rd_data and rd_valid unchanged; after rd_ready=1, one entry is accepted per cycle with no gaps.
- Abort mid-POST, then re-arm in the same cycle -> next cycle IDLE; arm ignored; rd_valid never asserted. A following arm starts a clean capture with count=0.
- IR trigger (mode=2, trig_ir=0x76), post_count=0, first sample ir=0x76 -> exactly one beat with rd_valid=1 and rd_last=1. A post_count of 9 with DEPTH=8 is clamped to 7.
